// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - request/grant/counter bundle for counter_sequencer; COUNTER_SEQ_ABORT_EN adds abort/aborted
interface counter_sequencer_if #(
    parameter int NREQ = 4,
    parameter int CW   = 3
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [CW-1:0]      count;
    logic               done;
    logic [IDW-1:0]     done_id;
`ifdef COUNTER_SEQ_ABORT_EN
    logic               abort;
    logic               aborted;

    modport master (
        output req, len, abort,
        input  grant, busy, count, done, done_id, aborted
    );
    modport slave (
        input  req, len, abort,
        output grant, busy, count, done, done_id, aborted
    );
`else
    modport master (
        output req, len,
        input  grant, busy, count, done, done_id
    );
    modport slave (
        input  req, len,
        output grant, busy, count, done, done_id
    );
`endif
endinterface

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - round-robin sharing of one up-counter among requesters; COUNTER_SEQ_ABORT_EN adds run abort
module counter_sequencer #(
    parameter int NREQ = 4,
    parameter int CW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    counter_sequencer_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [NREQ-1:0] grant_q;
    logic            busy_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   target_q;
    logic            done_q;
    logic [IDW-1:0]  done_id_q;
    logic [IDW-1:0]  served_q;
    logic [IDW-1:0]  ptr_q;

    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic [CW-1:0]   pick_len;
    logic [IDW-1:0]  ptr_next;
    logic            abort_hit;

`ifdef COUNTER_SEQ_ABORT_EN
    logic            aborted_q;
    assign abort_hit   = bus.abort;
    assign bus.aborted = aborted_q;
`else
    assign abort_hit   = 1'b0;
`endif

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.count   = count_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;

    // First requesting index at or above the pointer, wrapping; scanning downward lets the nearest one win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(ptr_q) + k) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign pick_len = bus.len[int'(pick_idx) * CW +: CW];
    assign ptr_next = (served_q == IDW'(NREQ - 1)) ? '0 : served_q + 1'b1;

    // Sequencer: arbitrate in IDLE, count in RUN, pulse completion in DONE; all outputs registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            target_q  <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            served_q  <= '0;
            ptr_q     <= '0;
`ifdef COUNTER_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
`ifdef COUNTER_SEQ_ABORT_EN
                    aborted_q <= 1'b0;
`endif
                    if (pick_valid) begin
                        grant_q  <= NREQ'(1) << pick_idx;
                        busy_q   <= 1'b1;
                        count_q  <= '0;
                        target_q <= pick_len;
                        served_q <= pick_idx;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort_hit || count_q == target_q) begin
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        count_q   <= '0;
                        done_q    <= 1'b1;
                        done_id_q <= served_q;
                        ptr_q     <= ptr_next;
`ifdef COUNTER_SEQ_ABORT_EN
                        aborted_q <= abort_hit;
`endif
                        state     <= DONE;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
`ifdef COUNTER_SEQ_ABORT_EN
                    aborted_q <= 1'b0;
`endif
                    state  <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                    done_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
